// File: rtl/mem_arbiter.sv
// Two-requester arbiter (r0 = CPU, r1 = loader/debug) in front of one synchronous RAM.
// Define ARB_FIXED_PRIO_EN for fixed r0 priority on ties; the default build is round-robin.
module mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        r0_cmd,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_ready,
    input  logic [1:0]        r1_cmd,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_ready,
    output logic [ADDR_W-2:0] ram_addr,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    logic [1:0]        state_q, state_d;
    logic              grant_q;            // 0: r0, 1: r1
    logic              cap_read_q;
    logic              cap_inrange_q;
    logic              r0_pend, r1_pend, any_pend;
    logic              winner;
    logic              in_access;
    logic [1:0]        g_cmd;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    // A requester showing its ready pulse is not pending, so a stale held command is skipped.
    assign r0_pend  = (r0_cmd == MREAD || r0_cmd == MWRITE) && !r0_ready;
    assign r1_pend  = (r1_cmd == MREAD || r1_cmd == MWRITE) && !r1_ready;
    assign any_pend = r0_pend || r1_pend;

`ifdef ARB_FIXED_PRIO_EN
    assign winner = !r0_pend;
`else
    logic last_grant_q;

    always_comb begin
        if (r0_pend && r1_pend) begin
            winner = ~last_grant_q;
        end else begin
            winner = r1_pend;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (state_q == IDLE && any_pend) begin
            last_grant_q <= winner;
        end
    end
`endif

    assign g_cmd   = grant_q ? r1_cmd   : r0_cmd;
    assign g_addr  = grant_q ? r1_addr  : r0_addr;
    assign g_wdata = grant_q ? r1_wdata : r0_wdata;

    // Reset in the access cycle aborts the transfer before the RAM sees a write.
    assign in_access = (state_q == ACCESS) && !reset;
    assign ram_addr  = in_access ? g_addr[ADDR_W-2:0] : '0;
    assign ram_din   = in_access ? g_wdata : '0;
    assign ram_write = in_access && (g_cmd == MWRITE) && g_addr[ADDR_W-1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_pend) state_d = ACCESS;
            ACCESS:  state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            cap_read_q    <= 1'b0;
            cap_inrange_q <= 1'b0;
            r0_ready      <= 1'b0;
            r1_ready      <= 1'b0;
            r0_rdata      <= '0;
            r1_rdata      <= '0;
        end else begin
            state_q  <= state_d;
            r0_ready <= 1'b0;
            r1_ready <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_pend) grant_q <= winner;
                end
                ACCESS: begin
                    cap_read_q    <= (g_cmd == MREAD);
                    cap_inrange_q <= g_addr[ADDR_W-1];
                end
                CAPTURE: begin
                    // Out-of-range reads return zero; writes leave rdata untouched.
                    if (grant_q) begin
                        r1_ready <= 1'b1;
                        if (cap_read_q) r1_rdata <= cap_inrange_q ? ram_dout : '0;
                    end else begin
                        r0_ready <= 1'b1;
                        if (cap_read_q) r0_rdata <= cap_inrange_q ? ram_dout : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a reservation-style reference model predicts
// every ready pulse, rdata value and RAM write; a separate monitor checks the DUT against it.
module tb_mem_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam logic [1:0] MNONE = 2'b00, MREAD = 2'b01, MWRITE = 2'b10;

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] data;
        bit          late;   // keep presenting the command through the ready cycle
        bit          abort;  // drop the command if a reset hits while it is outstanding
    } op_t;

    typedef struct { int cyc; logic [15:0] data; } rd_exp_t;
    typedef struct { int cyc; logic [7:0] addr; logic [15:0] data; } wr_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  r0_cmd, r1_cmd;
    logic [8:0]  r0_addr, r1_addr;
    logic [15:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata;
    logic        r0_ready, r1_ready;
    logic [7:0]  ram_addr;
    logic        ram_write;
    logic [15:0] ram_din, ram_dout;

    logic [15:0] ram [256];
    logic [15:0] ref_mem [256];
    int          cyc = 0;
    int          chk_cnt = 0;
    int          fail_cnt = 0;

    rd_exp_t exp_q0[$], exp_q1[$];
    wr_exp_t wr_q[$], mwr_q[$];
    op_t     ops0[$], ops1[$];
    op_t     cur [2];
    bit      has [2];
    bit      stale [2];

    // model state
    int          free_at = 0;
    bit          last_rr = 1'b1;
    int          rdy_at [2] = '{-1, -1};
    logic [15:0] ref_rdata [2] = '{16'h0, 16'h0};
    int          rst_plan = -1;

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .r0_cmd(r0_cmd), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rdata(r0_rdata), .r0_ready(r0_ready),
        .r1_cmd(r1_cmd), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rdata(r1_rdata), .r1_ready(r1_ready),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic op_t mk(input logic [1:0] cmd, input logic [8:0] addr,
                               input logic [15:0] data, input bit late, input bit abort);
        op_t o;
        o.cmd = cmd; o.addr = addr; o.data = data; o.late = late; o.abort = abort;
        return o;
    endfunction

    function automatic op_t rand_op();
        int         r;
        logic [7:0] lo;
        logic [1:0] cmd;
        r   = $urandom_range(0, 9);
        cmd = (r == 0) ? 2'b11 : (r < 3) ? MNONE : (r < 6) ? MREAD : MWRITE;
        lo  = 8'($urandom_range(0, 7) * 37);
        return mk(cmd, {1'($urandom_range(0, 3) != 0), lo}, 16'($urandom),
                  $urandom_range(0, 3) == 0, 1'b0);
    endfunction

    // RAM model: registered read-first port, plus the cycle counter.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
        forever begin
            @(posedge clk);
            ram_dout <= ram[ram_addr];
            if (ram_write === 1'b1) ram[ram_addr] = ram_din;
            cyc <= cyc + 1;
        end
    end

    task automatic advance(input int i);
        stale[i] = 1'b0;
        if (i == 0) begin
            has[0] = ops0.size() > 0;
            if (has[0]) cur[0] = ops0.pop_front();
        end else begin
            has[1] = ops1.size() > 0;
            if (has[1]) cur[1] = ops1.pop_front();
        end
    endtask

    task automatic agent(input int i, input logic rdy, input bit prev_rst);
        if (!has[i]) advance(i);
        else if (prev_rst && cur[i].abort) advance(i);
        else if (cur[i].cmd != MREAD && cur[i].cmd != MWRITE) advance(i);
        else if (rdy) begin
            if (cur[i].late && !stale[i]) stale[i] = 1'b1;
            else advance(i);
        end else if (stale[i]) advance(i);
    endtask

    // Arbiter as a shared resource: a grant at cycle c reserves it until c+3, when the
    // winner's ready pulse appears; the RAM is touched at c+1.
    task automatic model_step(input int c);
        bit          p0, p1;
        int          w;
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] data;
        rd_exp_t     e;
        wr_exp_t     wr;
        if (reset) begin
            while (exp_q0.size() > 0 && exp_q0[$].cyc > c) void'(exp_q0.pop_back());
            while (exp_q1.size() > 0 && exp_q1[$].cyc > c) void'(exp_q1.pop_back());
            while (wr_q.size() > 0 && wr_q[$].cyc >= c) void'(wr_q.pop_back());
            while (mwr_q.size() > 0 && mwr_q[$].cyc >= c) void'(mwr_q.pop_back());
        end
        while (mwr_q.size() > 0 && mwr_q[0].cyc < c) begin
            wr = mwr_q.pop_front();
            ref_mem[wr.addr] = wr.data;
        end
        if (reset) begin
            free_at = c + 1; last_rr = 1'b1;
            rdy_at[0] = -1; rdy_at[1] = -1;
            ref_rdata[0] = '0; ref_rdata[1] = '0;
            return;
        end
        if (c < free_at) return;
        p0 = (r0_cmd == MREAD || r0_cmd == MWRITE) && rdy_at[0] != c;
        p1 = (r1_cmd == MREAD || r1_cmd == MWRITE) && rdy_at[1] != c;
        if (!p0 && !p1) return;
`ifdef ARB_FIXED_PRIO_EN
        w = p0 ? 0 : 1;
`else
        w = (p0 && p1) ? (last_rr ? 0 : 1) : (p1 ? 1 : 0);
`endif
        last_rr = (w == 1);
        free_at = c + 3;
        rdy_at[w] = c + 3;
        cmd  = (w == 0) ? r0_cmd : r1_cmd;
        addr = (w == 0) ? r0_addr : r1_addr;
        data = (w == 0) ? r0_wdata : r1_wdata;
        if (cmd == MWRITE) begin
            if (addr[8]) begin
                wr.cyc = c + 1; wr.addr = addr[7:0]; wr.data = data;
                wr_q.push_back(wr);
                mwr_q.push_back(wr);
            end
            if (w == 0 && addr == 9'h1FF && cur[0].abort) rst_plan = c + 1;
        end else begin
            ref_rdata[w] = addr[8] ? ref_mem[addr[7:0]] : 16'h0;
        end
        e.cyc = c + 3; e.data = ref_rdata[w];
        if (w == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    // Stimulus
    initial begin
        int c;
        bit prev_rst;
        bit done;
        reset = 1'b1;
        r0_cmd = MNONE; r0_addr = '0; r0_wdata = '0;
        r1_cmd = MNONE; r1_addr = '0; r1_wdata = '0;
        has[0] = 1'b0; has[1] = 1'b0; stale[0] = 1'b0; stale[1] = 1'b0;
        prev_rst = 1'b1;
        done = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];
        ops0.push_back(mk(MREAD,  9'h110, 16'h0,    1'b0, 1'b0));
        ops0.push_back(mk(MWRITE, 9'h105, 16'hABCD, 1'b0, 1'b0));
        ops0.push_back(mk(MREAD,  9'h105, 16'h0,    1'b1, 1'b0));
        ops0.push_back(mk(MREAD,  9'h101, 16'h0,    1'b1, 1'b0));
        ops0.push_back(mk(MREAD,  9'h101, 16'h0,    1'b0, 1'b0));
        ops0.push_back(mk(MWRITE, 9'h1FF, 16'h5A5A, 1'b0, 1'b1));
        ops0.push_back(mk(MREAD,  9'h1FF, 16'h0,    1'b0, 1'b0));
        ops1.push_back(mk(MREAD,  9'h120, 16'h0,    1'b0, 1'b0));
        ops1.push_back(mk(MWRITE, 9'h040, 16'h1234, 1'b0, 1'b0));
        ops1.push_back(mk(MREAD,  9'h040, 16'h0,    1'b0, 1'b0));
        for (int i = 0; i < 150; i++) begin
            ops0.push_back(rand_op());
            ops1.push_back(rand_op());
        end
        while (!done) begin
            @(posedge clk);
            #1;
            c = cyc;
            agent(0, r0_ready, prev_rst);
            agent(1, r1_ready, prev_rst);
            reset = (c < 3) || (c == rst_plan) || (c > 60 && $urandom_range(0, 299) == 0);
            r0_cmd   = has[0] ? cur[0].cmd  : MNONE;
            r0_addr  = has[0] ? cur[0].addr : '0;
            r0_wdata = has[0] ? cur[0].data : '0;
            r1_cmd   = has[1] ? cur[1].cmd  : MNONE;
            r1_addr  = has[1] ? cur[1].addr : '0;
            r1_wdata = has[1] ? cur[1].data : '0;
            model_step(c);
            prev_rst = reset;
            if (!has[0] && !has[1] && ops0.size() == 0 && ops1.size() == 0) done = 1'b1;
            if (c > 8000) begin
                check("stimulus completes in cycle budget", 32'(c), 32'd8000);
                done = 1'b1;
            end
        end
        reset = 1'b0;
        r0_cmd = MNONE; r1_cmd = MNONE;
        repeat (6) @(posedge clk);
        #1;
        check("r0 expected responses drained", 32'(exp_q0.size()), 32'd0);
        check("r1 expected responses drained", 32'(exp_q1.size()), 32'd0);
        check("expected RAM writes drained", 32'(wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

    // Monitor: pops expected responses when due and compares against the DUT outputs.
    initial begin
        logic [15:0] m0, m1;
        rd_exp_t     e;
        wr_exp_t     w;
        m0 = '0; m1 = '0;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                check("r0/r1 ready exclusive", {31'b0, r0_ready & r1_ready}, 32'd0);
                while (exp_q0.size() > 0 && exp_q0[0].cyc < cyc) void'(exp_q0.pop_front());
                if (exp_q0.size() > 0 && exp_q0[0].cyc == cyc) begin
                    check("r0_ready pulse", {31'b0, r0_ready}, 32'd1);
                    e = exp_q0.pop_front();
                    m0 = e.data;
                end else check("r0_ready idle", {31'b0, r0_ready}, 32'd0);
                check("r0_rdata", {16'b0, r0_rdata}, {16'b0, m0});
                while (exp_q1.size() > 0 && exp_q1[0].cyc < cyc) void'(exp_q1.pop_front());
                if (exp_q1.size() > 0 && exp_q1[0].cyc == cyc) begin
                    check("r1_ready pulse", {31'b0, r1_ready}, 32'd1);
                    e = exp_q1.pop_front();
                    m1 = e.data;
                end else check("r1_ready idle", {31'b0, r1_ready}, 32'd0);
                check("r1_rdata", {16'b0, r1_rdata}, {16'b0, m1});
                while (wr_q.size() > 0 && wr_q[0].cyc < cyc) void'(wr_q.pop_front());
                if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                    w = wr_q.pop_front();
                    check("ram_write asserted", {31'b0, ram_write}, 32'd1);
                    check("ram_addr", {24'b0, ram_addr}, {24'b0, w.addr});
                    check("ram_din", {16'b0, ram_din}, {16'b0, w.data});
                end else check("ram_write quiet", {31'b0, ram_write}, 32'd0);
                if (reset) begin
                    m0 = '0;
                    m1 = '0;
                end
            end
        end
    end

endmodule
